// File: rtl/mem_rr_sched.sv
// Round-robin scheduler sharing one single-port dmem among C cores.
// Define LOCK_TABLE_EN to add the 2^LW-entry mutex lock table and its ports.
module mem_rr_sched #(
    parameter int C  = 8,
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int LW = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [C-1:0]         req_valid,
    input  logic [C-1:0]         req_write,
    input  logic [C-1:0][AW-1:0] req_adr,
    input  logic [C-1:0][DW-1:0] req_dat,
    output logic [C-1:0]         req_ready,
    output logic [AW-1:0]        mem_adr,
    output logic [DW-1:0]        mem_wdat,
    output logic                 mem_we,
    input  logic [DW-1:0]        mem_rdat,
    output logic [C-1:0]         rsp_valid,
    output logic [DW-1:0]        rsp_dat
`ifdef LOCK_TABLE_EN
    ,
    input  logic [C-1:0]         lock_req,
    input  logic [C-1:0]         unlock_req,
    input  logic [C-1:0][LW-1:0] lock_adr,
    output logic [C-1:0]         lock_ack,
    output logic [C-1:0]         lock_fail
`endif
);

    localparam int PW = $clog2(C);

    // First set bit of vec scanning upward from ptr, wrapping modulo C.
    function automatic logic [PW-1:0] rr_idx(input logic [C-1:0] vec, input logic [PW-1:0] ptr);
        logic [PW-1:0] result;
        logic [PW-1:0] cand;
        logic          found;
        result = '0;
        found  = 1'b0;
        for (int i = 0; i < C; i++) begin
            cand = ptr + PW'(i);
            if (!found && vec[cand]) begin
                result = cand;
                found  = 1'b1;
            end else begin
                found  = found;
            end
        end
        return result;
    endfunction

    logic [PW-1:0] ptr_r;
    logic [PW-1:0] win_idx_s;
    logic          any_req_s;
    logic [C-1:0]  grant_s;
    logic [C-1:0]  rsp_valid_r;

    // Memory arbitration; every pin is forced idle while reset is asserted.
    always_comb begin
        win_idx_s = rr_idx(req_valid, ptr_r);
        any_req_s = |req_valid;
        grant_s   = '0;
        mem_adr   = '0;
        mem_wdat  = '0;
        mem_we    = 1'b0;
        if (reset && any_req_s) begin
            grant_s[win_idx_s] = 1'b1;
            mem_adr            = req_adr[win_idx_s];
            mem_wdat           = req_dat[win_idx_s];
            mem_we             = req_write[win_idx_s];
        end else begin
            grant_s = '0;
        end
    end

    // Pointer rotation and one-cycle-delayed read-response valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r       <= '0;
            rsp_valid_r <= '0;
        end else begin
            if (any_req_s) begin
                ptr_r <= win_idx_s + PW'(1);
            end else begin
                ptr_r <= ptr_r;
            end
            rsp_valid_r <= grant_s & ~req_write;
        end
    end

    assign req_ready = grant_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_dat   = mem_rdat;

`ifdef LOCK_TABLE_EN
    logic [(2**LW)-1:0] lock_bits_r;
    logic [PW-1:0]      lock_ptr_r;
    logic [PW-1:0]      lock_win_s;
    logic [C-1:0]       lock_cand_s;
    logic               lock_any_s;
    logic               lock_busy_s;
    logic [C-1:0]       lock_ack_r;
    logic [C-1:0]       lock_fail_r;

    // Cores in their response cycle are masked so a held lock_req is not re-served.
    always_comb begin
        lock_cand_s = lock_req & ~(lock_ack_r | lock_fail_r);
        lock_any_s  = |lock_cand_s;
        lock_win_s  = rr_idx(lock_cand_s, lock_ptr_r);
        lock_busy_s = lock_bits_r[lock_adr[lock_win_s]];
    end

    // Lock grant, responses and table update; unlocks are applied last so a
    // same-index lock/unlock pair fails the lock and leaves the bit clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_bits_r <= '0;
            lock_ptr_r  <= '0;
            lock_ack_r  <= '0;
            lock_fail_r <= '0;
        end else begin
            lock_ack_r  <= '0;
            lock_fail_r <= '0;
            if (lock_any_s) begin
                lock_ptr_r <= lock_win_s + PW'(1);
                if (lock_busy_s) begin
                    lock_fail_r[lock_win_s] <= 1'b1;
                end else begin
                    lock_ack_r[lock_win_s]              <= 1'b1;
                    lock_bits_r[lock_adr[lock_win_s]] <= 1'b1;
                end
            end else begin
                lock_ptr_r <= lock_ptr_r;
            end
            for (int i = 0; i < C; i++) begin
                if (unlock_req[i]) begin
                    lock_bits_r[lock_adr[i]] <= 1'b0;
                end
            end
        end
    end

    assign lock_ack  = lock_ack_r;
    assign lock_fail = lock_fail_r;
`endif

endmodule

// File: tb/tb_mem_rr_sched.sv
// Directed bench for mem_rr_sched: grant checks inline, read responses via a
// scoreboard queue popped by an independent monitor. Lock tests need LOCK_TABLE_EN.
module tb_mem_rr_sched;

    localparam int C  = 8;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LW = 10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [C-1:0]         req_valid;
    logic [C-1:0]         req_write;
    logic [C-1:0][AW-1:0] req_adr;
    logic [C-1:0][DW-1:0] req_dat;
    logic [C-1:0]         req_ready;
    logic [AW-1:0]        mem_adr;
    logic [DW-1:0]        mem_wdat;
    logic                 mem_we;
    logic [DW-1:0]        mem_rdat;
    logic [C-1:0]         rsp_valid;
    logic [DW-1:0]        rsp_dat;
`ifdef LOCK_TABLE_EN
    logic [C-1:0]         lock_req;
    logic [C-1:0]         unlock_req;
    logic [C-1:0][LW-1:0] lock_adr;
    logic [C-1:0]         lock_ack;
    logic [C-1:0]         lock_fail;
`endif

    mem_rr_sched #(.C(C), .AW(AW), .DW(DW), .LW(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .req_ready (req_ready),
        .mem_adr   (mem_adr),
        .mem_wdat  (mem_wdat),
        .mem_we    (mem_we),
        .mem_rdat  (mem_rdat),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat)
`ifdef LOCK_TABLE_EN
        ,
        .lock_req  (lock_req),
        .unlock_req(unlock_req),
        .lock_adr  (lock_adr),
        .lock_ack  (lock_ack),
        .lock_fail (lock_fail)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dmem model: registered read; unwritten words read back as ~address.
    logic [DW-1:0] wram [0:255];
    logic [255:0]  wvld = '0;
    always @(posedge clk) begin
        if (mem_we) begin
            wram[mem_adr[7:0]] <= mem_wdat;
            wvld[mem_adr[7:0]] <= 1'b1;
        end
        mem_rdat <= wvld[mem_adr[7:0]] ? wram[mem_adr[7:0]] : ~mem_adr;
    end

    typedef struct {
        int           cyc;
        logic [C-1:0] v;
        logic [DW-1:0] d;
    } rsp_t;
    rsp_t exp_q[$];
    rsp_t mon_e;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called right after inputs are set at a negedge; checks the grant and
    // queues the read response expected on the next cycle.
    task automatic step(input int exp_w, input logic [DW-1:0] exp_rd);
        #1;
        chk("grant", req_ready, (exp_w < 0) ? 32'd0 : (32'd1 << exp_w));
        if (exp_w >= 0) begin
            chk("mem_adr", mem_adr, req_adr[exp_w]);
            chk("mem_we", mem_we, req_write[exp_w]);
            if (!req_write[exp_w]) begin
                mon_push(cyc + 1, C'(1) << exp_w, exp_rd);
            end
        end
    endtask

    task automatic mon_push(input int c, input logic [C-1:0] v, input logic [DW-1:0] d);
        rsp_t e;
        e.cyc = c;
        e.v   = v;
        e.d   = d;
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(negedge clk);
        if (reset === 1'b1 && rsp_valid !== '0) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_cycle", cyc, mon_e.cyc);
                chk("rsp_valid", rsp_valid, mon_e.v);
                chk("rsp_dat", rsp_dat, mon_e.d);
            end
        end
    end

    initial begin
        reset     = 1'b0;
        req_valid = '1;
        req_write = '1;
        req_adr   = '0;
        req_dat   = '0;
`ifdef LOCK_TABLE_EN
        lock_req   = '0;
        unlock_req = '0;
        lock_adr   = '0;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", req_ready, 32'd0);
        chk("rst_we", mem_we, 32'd0);
        chk("rst_rsp", rsp_valid, 32'd0);

        @(negedge clk);
        req_valid = '0;
        req_write = '0;
        reset     = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("idle_ready", req_ready, 32'd0);
            chk("idle_we", mem_we, 32'd0);
            chk("idle_rsp", rsp_valid, 32'd0);
        end

        // Rotation: everyone reads continuously from ptr=0.
        for (int i = 0; i < C; i++) req_adr[i] = 16'h0100 + 16'(i);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            req_valid = '1;
            step(k % C, ~(16'h0100 + 16'(k % C)));
        end

        // ptr=1: core 3 writes 0xBEEF, core 5 reads it back next cycle.
        @(negedge clk);
        req_valid  = 8'b0000_1000;
        req_write  = 8'b0000_1000;
        req_adr[3] = 16'h0040;
        req_dat[3] = 16'hBEEF;
        step(3, 16'h0000);
        chk("wr_wdat", mem_wdat, 32'h0000_BEEF);
        @(negedge clk);
        req_valid  = 8'b0010_0000;
        req_write  = 8'b0000_0000;
        req_adr[5] = 16'h0040;
        step(5, 16'hBEEF);

        // ptr=6: only cores 1 and 6 request.
        req_adr[1] = 16'h0201;
        req_adr[6] = 16'h0206;
        @(negedge clk); req_valid = 8'b0100_0010; step(6, ~16'h0206);
        @(negedge clk); step(1, ~16'h0201);
        @(negedge clk); step(6, ~16'h0206);
        @(negedge clk); step(1, ~16'h0201);
        @(negedge clk); req_valid = '0; step(-1, 16'h0000);

`ifdef LOCK_TABLE_EN
        // Cores 2 and 4 contend for index 0x155.
        @(negedge clk);
        lock_adr[2] = 10'h155;
        lock_adr[4] = 10'h155;
        lock_req    = 8'b0001_0100;
        @(negedge clk); #1;
        chk("lk_ack2", lock_ack, 32'h04);
        chk("lk_nofail", lock_fail, 32'h00);
        lock_req[2] = 1'b0;
        @(negedge clk); #1;
        chk("lk_noack", lock_ack, 32'h00);
        chk("lk_fail4", lock_fail, 32'h10);
        unlock_req[2] = 1'b1;
        @(negedge clk); #1;
        unlock_req = '0;
        chk("lk_gap_ack", lock_ack, 32'h00);
        chk("lk_gap_fail", lock_fail, 32'h00);
        @(negedge clk); #1;
        chk("lk_ack4", lock_ack, 32'h10);
        chk("lk_nofail4", lock_fail, 32'h00);
        lock_req = '0;
`endif

        // Reset in the cycle after a read grant drops the pending response.
        @(negedge clk);
        req_valid  = 8'b0000_1000;
        req_adr[3] = 16'h0300;
        #1;
        chk("pre_rst_grant", req_ready, 32'h08);
        @(posedge clk);
        #2;
        chk("pre_rst_rsp", rsp_valid, 32'h08);
        reset = 1'b0;
        #1;
        chk("mid_rst_rsp", rsp_valid, 32'h00);
        chk("mid_rst_ready", req_ready, 32'h00);
        @(negedge clk);
        reset      = 1'b1;
        req_valid  = 8'b0010_0100;
        req_adr[2] = 16'h0302;
        req_adr[5] = 16'h0305;
        step(2, ~16'h0302);
        @(negedge clk); step(5, ~16'h0305);
        @(negedge clk); req_valid = '0; step(-1, 16'h0000);

`ifdef LOCK_TABLE_EN
        // The lock core 4 held before reset must be gone.
        @(negedge clk);
        lock_adr[0] = 10'h155;
        lock_req    = 8'b0000_0001;
        @(negedge clk); #1;
        chk("post_rst_lock", lock_ack, 32'h01);
        lock_req = '0;
`endif

        repeat (3) @(negedge clk);
        #1;
        chk("exp_q_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_rr_sched.md
Name: mem_rr_sched

Overview:
- Round-robin scheduler that shares the single-port data memory (dmem) between C core requesters.
- Grants at most one memory access per cycle, drives the dmem address, write-data and write-enable pins, and routes read data back to the owning core with a registered one-hot valid.
- Optionally hosts the mutex lock table, with real per-core lock success and fail responses.
- Sits between the core array and dmem, in place of the fixed-counter priority selection.

Parameters:
- C, 8, number of requesting cores (power of two, 2..16)
- AW, 16, memory address width
- DW, 16, memory data width
- LW, 10, lock address width (the lock table holds 2^LW entries)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  C  per-core access request
- req_write  in  C  1 = write, 0 = read
- req_adr  in  [C-1:0][AW]  per-core address
- req_dat  in  [C-1:0][DW]  per-core write data
- req_ready  out  C  one-hot grant, combinational; the access is accepted when req_valid[i] and req_ready[i] are both 1
- mem_adr  out  AW  to dmem address
- mem_wdat  out  DW  to dmem write data
- mem_we  out  1  to dmem write enable
- mem_rdat  in  DW  from dmem; registered output, valid the cycle after the address
- rsp_valid  out  C  registered one-hot read-data valid
- rsp_dat  out  DW  equals mem_rdat
- lock_req  in  C  (LOCK_TABLE_EN) level lock request
- unlock_req  in  C  (LOCK_TABLE_EN) unlock request, one cycle
- lock_adr  in  [C-1:0][LW]  (LOCK_TABLE_EN) lock index per core
- lock_ack  out  C  (LOCK_TABLE_EN) registered one-hot, lock obtained
- lock_fail  out  C  (LOCK_TABLE_EN) registered one-hot, lock busy

Behaviour:
- Reset (reset=0, asynchronous):
  - ptr=0, rsp_valid=0, lock_ack=0, lock_fail=0, lock_ptr=0, all lock bits cleared.
  - req_ready=0 and mem_we=0 while reset is asserted; combinational outputs are gated by reset.
- Memory arbitration:
  - ptr is a clog2(C)-bit register.
  - Winner w = first i with req_valid[i], scanning ptr, ptr+1, ... modulo C.
  - req_ready = one-hot(w); mem_adr=req_adr[w], mem_wdat=req_dat[w], mem_we=req_write[w].
  - No request: req_ready=0, mem_we=0, mem_adr=0, mem_wdat=0, ptr holds.
  - On grant: ptr <= (w+1) mod C, wrapping from C-1 to 0.
- Fairness: a core holding req_valid is granted within C cycles, i.e. after at most C-1 other grants.
- Latency:
  - Write completes at the grant edge.
  - Read: rsp_valid[w]=1 exactly one cycle after the grant, with rsp_dat = mem_rdat in that same cycle.
  - Writes produce no rsp_valid.
- Pipelining: back-to-back grants to the same or different cores are allowed every cycle.
  - Read-after-write to the same address in the next cycle returns the new data.
- Requester protocol:
  - req_valid may drop without a grant; there is no obligation to hold.
  - req_* fields are sampled only in the grant cycle.
- Lock table, 2^LW bits:
  - Unlock: every core with unlock_req clears bit lock_adr[i] at posedge, any number per cycle.
  - Lock candidates = lock_req & ~(lock_ack | lock_fail). This masks a core during its response cycle.
  - Round-robin winner over the candidates uses lock_ptr, with the same rule as ptr; lock_ptr advances only on a winner.
  - Winner with bit clear: set the bit, and lock_ack[w]=1 next cycle.
  - Winner with bit set: lock_fail[w]=1 next cycle, bit unchanged.
  - Response pulses last exactly one cycle; the core deasserts lock_req on seeing the response, or retries after fail.
  - Same-cycle lock and unlock of the same index: the lock sees the pre-edge value (set, so it fails) and the unlock clears the bit; net bit = 0.
  - Non-winning candidates get no response and stay pending.
- Reset mid-operation: any pending rsp_valid or lock response is dropped, and all locks are released.

Optional Feature:
- Macro: LOCK_TABLE_EN.
- Defined: lock ports and lock table present, as specified under Behaviour.
- Undefined: lock_req, unlock_req, lock_adr, lock_ack and lock_fail ports are absent; no lock storage or arbitration is generated; the memory scheduler is unchanged.

Test Plan:
- Reset then idle: reset low, then high, no requests -> req_ready=0, mem_we=0, rsp_valid=0 for 10 cycles.
- Round-robin rotation: all 8 cores issue reads continuously from ptr=0 -> grant order 0,1,...,7,0; rsp_valid one-hot follows each grant by 1 cycle.
- Write then read:
  - Core 3 writes 0xBEEF to adr 0x0040; core 5 reads 0x0040 in the next cycle.
  - Expected: rsp_valid=8'b0010_0000 and rsp_dat=0xBEEF two cycles after the write grant.
- Pointer wrap and skip: ptr=6, only cores 1 and 6 request -> grant 6, then 1, then 6; ptr is 7, then 2, then 7.
- Lock contention (LOCK_TABLE_EN):
  - Cores 2 and 4 both lock_req index 0x155, lock_ptr=0.
  - Expected: lock_ack[2] next cycle; core 4 is granted in the following cycle and gets lock_fail[4].
  - Core 2 unlocks; core 4 retries -> lock_ack[4].
- Async reset mid-read: assert reset in the cycle after a read grant -> rsp_valid=0 immediately and all lock bits 0; the first access after release is granted to the lowest requesting core.
